// File: rtl/cfg_profile_pkg.sv
// Shared types and width helpers for the configuration profile sequencer.
package cfg_profile_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_APPLY,
        ST_SETTLE,
        ST_RELEASE
    } state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Wide enough to hold the larger of the two terminal counts without wrapping.
    function automatic int unsigned cnt_width(input int unsigned t, input int unsigned s);
        return $clog2(((t > s) ? t : s) + 1);
    endfunction

endpackage

// File: rtl/cfg_profile_cnt.sv
// Clearable saturating up-counter; clear has priority over enable.
module cfg_profile_cnt #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cfg_profile_sequencer.sv
// Switches the active configuration profile under a drain/apply/settle/release
// handshake with the downstream channels.
module cfg_profile_sequencer
    import cfg_profile_pkg::*;
#(
    parameter int unsigned NumProfiles   = 3,
    parameter int unsigned NumChannels   = 4,
    parameter int unsigned CfgWidth      = 32,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned SettleCycles  = 4
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [idx_width(NumProfiles)-1:0]     req_profile_i,
    input  logic [NumProfiles-1:0][CfgWidth-1:0]  profiles_i,
    output logic [NumChannels-1:0]                quiesce_req_o,
    input  logic [NumChannels-1:0]                quiesce_ack_i,
    output logic [CfgWidth-1:0]                   cfg_o,
    output logic [idx_width(NumProfiles)-1:0]     active_profile_o,
    output logic                                  busy_o,
    output logic                                  err_timeout_o,
    output logic                                  err_invalid_o
);

    localparam int unsigned     IdxW       = idx_width(NumProfiles);
    localparam int unsigned     CntW       = cnt_width(TimeoutCycles, SettleCycles);
    localparam logic [IdxW:0]   ProfLimit  = (IdxW+1)'(NumProfiles);
    localparam logic [CntW-1:0] TmoLast    = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);

    state_e          state_q, state_d;
    logic [IdxW-1:0] target_q, target_d;
    logic [IdxW-1:0] active_q, active_d;
    logic            err_tmo_q, err_tmo_d;
    logic            err_inv_q, err_inv_d;
    logic [CntW-1:0] tmo_cnt, settle_cnt;
    logic            cnt_clr;
    logic            quiesce_on;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        active_d  = active_q;
        err_tmo_d = 1'b0;
        err_inv_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if ({1'b0, req_profile_i} >= ProfLimit) begin
                        err_inv_d = 1'b1;
                    end else if (req_profile_i != active_q) begin
                        target_d = req_profile_i;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            // Full ack takes priority over a timeout landing in the same cycle.
            ST_DRAIN: begin
                if (&quiesce_ack_i) begin
                    state_d = ST_APPLY;
                end else if (tmo_cnt == TmoLast) begin
                    state_d   = ST_IDLE;
                    err_tmo_d = 1'b1;
                end
            end
            ST_APPLY: begin
                active_d = target_q;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt == SettleLast) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!(|quiesce_ack_i)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            target_q  <= '0;
            active_q  <= '0;
            err_tmo_q <= 1'b0;
            err_inv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            active_q  <= active_d;
            err_tmo_q <= err_tmo_d;
            err_inv_q <= err_inv_d;
        end
    end

    // Both counters restart from zero on every state transition.
    assign cnt_clr = (state_d != state_q);

    cfg_profile_cnt #(.Width(CntW)) u_tmo_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .en_i  (state_q == ST_DRAIN),
        .cnt_o (tmo_cnt)
    );

    cfg_profile_cnt #(.Width(CntW)) u_settle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .en_i  (state_q == ST_SETTLE),
        .cnt_o (settle_cnt)
    );

    assign quiesce_on       = (state_q == ST_DRAIN) || (state_q == ST_APPLY) || (state_q == ST_SETTLE);
    assign quiesce_req_o    = {NumChannels{quiesce_on}};
    assign req_ready_o      = (state_q == ST_IDLE);
    assign busy_o           = (state_q != ST_IDLE);
    assign active_profile_o = active_q;
    assign cfg_o            = profiles_i[active_q];
    assign err_timeout_o    = err_tmo_q;
    assign err_invalid_o    = err_inv_q;

endmodule

// File: tb/tb_cfg_profile_sequencer.sv
// Scoreboard bench: drivers queue the expected outcome of each request, a
// negedge monitor pops and compares whenever the DUT completes or flags an error.
module tb_cfg_profile_sequencer;

    localparam int EV_DONE = 0;
    localparam int EV_TMO  = 1;
    localparam int EV_INV  = 2;

    typedef struct {
        int          kind;
        int          prof;
        logic [31:0] cfg;
        int          qcyc;
    } ev_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [1:0]          req_profile = '0;
    logic [2:0][31:0]    profiles;
    logic [3:0]          quiesce_req;
    logic [3:0]          quiesce_ack;
    logic [31:0]         cfg;
    logic [1:0]          active_profile;
    logic                busy;
    logic                err_timeout;
    logic                err_invalid;

    int          checks = 0;
    int          errors = 0;
    ev_t         exp_q[$];
    int          ack_dly = 1;
    logic [3:0]  stuck = 4'b0000;
    int          qcnt = 0;

    always #5 clk = ~clk;

    cfg_profile_sequencer #(
        .NumProfiles  (3),
        .NumChannels  (4),
        .CfgWidth     (32),
        .TimeoutCycles(8),
        .SettleCycles (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_profile_i   (req_profile),
        .profiles_i      (profiles),
        .quiesce_req_o   (quiesce_req),
        .quiesce_ack_i   (quiesce_ack),
        .cfg_o           (cfg),
        .active_profile_o(active_profile),
        .busy_o          (busy),
        .err_timeout_o   (err_timeout),
        .err_invalid_o   (err_invalid)
    );

    // Channel model: qcnt = cycles quiesce has already been high before this one.
    always @(posedge clk or posedge rst) begin
        if (rst) qcnt <= 0;
        else if (|quiesce_req) qcnt <= qcnt + 1;
        else qcnt <= 0;
    end
    assign quiesce_ack = (qcnt >= ack_dly) ? ~stuck : 4'b0000;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic push(input int kind, input int prof, input logic [31:0] c, input int qc);
        ev_t e;
        e.kind = kind; e.prof = prof; e.cfg = c; e.qcyc = qc;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int kind, input int qc);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", kind, $time);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_active", active_profile, e.prof);
            chk("ev_cfg", cfg, e.cfg);
            if (e.kind != EV_INV) chk("ev_quiesce_cycles", qc, e.qcyc);
        end
    endtask

    initial begin : monitor
        bit busy_prev = 1'b0;
        int qcyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_prev = 1'b0;
                qcyc = 0;
            end else begin
                if (busy && !busy_prev) qcyc = 0;
                if (|quiesce_req) qcyc++;
                if (err_invalid) pop_check(EV_INV, 0);
                if (busy_prev && !busy) pop_check(err_timeout ? EV_TMO : EV_DONE, qcyc);
                else if (err_timeout) pop_check(EV_TMO, qcyc);
                busy_prev = busy;
            end
        end
    end

    task automatic do_req(input logic [1:0] p);
        req_valid   = 1'b1;
        req_profile = p;
        @(posedge clk); #1;
        req_valid   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk("wait_idle_bound", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bit seen;
        profiles[0] = 32'hA5A5_0000;
        profiles[1] = 32'h1111_2222;
        profiles[2] = 32'hDEAD_BEEF;

        // Reset values while reset is held
        #3;
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_quiesce", quiesce_req, 4'h0);
        chk("rst_errs", {err_timeout, err_invalid}, 2'b00);
        chk("rst_active", active_profile, 2'd0);
        chk("rst_cfg", cfg, 32'hA5A5_0000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Same profile: no-op
        do_req(2'd0);
        seen = 1'b0;
        repeat (4) begin
            if (!req_ready || busy || (|quiesce_req)) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("noop_quiet", seen, 1'b0);

        // Out-of-range index
        push(EV_INV, 0, 32'hA5A5_0000, 0);
        do_req(2'd3);
        seen = 1'b0;
        repeat (4) begin
            if (busy || (|quiesce_req)) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("invalid_quiet", seen, 1'b0);

        // Timeout: one channel never acks
        stuck = 4'b0100; ack_dly = 1;
        push(EV_TMO, 0, 32'hA5A5_0000, 8);
        do_req(2'd1);
        wait_idle();
        stuck = 4'b0000;

        // Basic switch; a request raised mid-switch must be ignored
        push(EV_DONE, 2, 32'hDEAD_BEEF, 7);
        do_req(2'd2);
        do_req(2'd1);
        wait_idle();

        // Acks land exactly on the last timeout cycle: ack wins
        ack_dly = 7;
        push(EV_DONE, 1, 32'h1111_2222, 13);
        do_req(2'd1);
        wait_idle();

        // Reset asserted during SETTLE
        ack_dly = 1;
        do_req(2'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_active", active_profile, 2'd2);
        chk("pre_rst_quiesce", quiesce_req, 4'hF);
        rst = 1'b1;
        #1;
        chk("midrst_quiesce", quiesce_req, 4'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_active", active_profile, 2'd0);
        chk("midrst_errs", {err_timeout, err_invalid}, 2'b00);
        chk("midrst_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Recovery switch after reset
        push(EV_DONE, 1, 32'h1111_2222, 7);
        do_req(2'd1);
        wait_idle();

        // Acks one cycle too late: timeout, profile 1 retained
        ack_dly = 8;
        push(EV_TMO, 1, 32'h1111_2222, 8);
        do_req(2'd0);
        wait_idle();

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_profile_sequencer.md
CFG_PROFILE_SEQUENCER -- requirements
Module: cfg_profile_sequencer

Interface
REQ-001 SHALL have parameter NumProfiles, default 3: number of selectable configuration profiles (at least 2).
REQ-002 SHALL have parameter NumChannels, default 4: number of subsystems quiesced around a switch (at least 1).
REQ-003 SHALL have parameter CfgWidth, default 32: bit-width of one flattened profile vector.
REQ-004 SHALL have parameter TimeoutCycles, default 1024: maximum number of DRAIN cycles before abort (at least 1).
REQ-005 SHALL have parameter SettleCycles, default 4: number of cycles the new profile is held under quiesce (at least 1).
REQ-006 SHALL have ports as follows.
- clk_i: input, 1 bit, the only clock.
- rst_i: input, 1 bit, asynchronous active-high reset.
- req_valid_i: input, 1 bit, switch request valid.
- req_ready_o: output, 1 bit, request accepted when valid and ready are both high.
- req_profile_i: input, IdxW = $clog2(NumProfiles) bits, target profile index.
- profiles_i: input, NumProfiles x CfgWidth, profile table; quasi-static.
- quiesce_req_o: output, NumChannels bits, per-channel quiesce request.
- quiesce_ack_i: input, NumChannels bits, per-channel quiesce acknowledge.
- cfg_o: output, CfgWidth bits, equals profiles_i[active_profile_o] combinationally.
- active_profile_o: output, IdxW bits, currently applied profile index.
- busy_o: output, 1 bit, high whenever the FSM is not in IDLE.
- err_timeout_o: output, 1 bit, one-cycle pulse on DRAIN abort.
- err_invalid_o: output, 1 bit, one-cycle pulse on an out-of-range request.

Function
REQ-007 SHALL implement FSM states IDLE, DRAIN, APPLY, SETTLE, RELEASE.
REQ-008 SHALL drive req_ready_o = 1 only in IDLE.
REQ-009 On accept with req_profile_i >= NumProfiles: pulse err_invalid_o the next cycle and stay in IDLE.
REQ-010 On accept with req_profile_i == active_profile_o: no-op; stay in IDLE; no quiesce, no error.
REQ-011 On any other accept: latch the target index and enter DRAIN the next cycle.
REQ-012 DRAIN: quiesce_req_o = all ones; the timeout counter increments each cycle from 0.
REQ-013 DRAIN exits to APPLY in the cycle after AND(quiesce_ack_i) is sampled 1.
REQ-014 DRAIN timeout: if the counter reaches TimeoutCycles-1 without all acks, go to IDLE, pulse err_timeout_o, drop quiesce_req_o, and leave active_profile_o unchanged.
REQ-015 Acks completing in the same cycle as timeout SHALL win; no error is raised in that case.
REQ-016 APPLY lasts exactly one cycle and writes the latched target to active_profile_o, visible the following cycle; quiesce_req_o stays high.
REQ-017 SETTLE: hold quiesce_req_o high for exactly SettleCycles cycles using the settle counter, then enter RELEASE.
REQ-018 RELEASE: quiesce_req_o = 0; enter IDLE in the cycle after OR(quiesce_ack_i) is sampled 0; no timeout applies.
REQ-019 req_valid_i SHALL be ignored outside IDLE; requests are never queued.
REQ-020 Counters SHALL be width $clog2(max(TimeoutCycles, SettleCycles)+1), cleared on every state entry, and SHALL never wrap.

Reset
REQ-021 Reset values: state IDLE, active_profile_o 0, quiesce_req_o 0, busy_o 0, both error outputs 0, counters 0; req_ready_o = 1 once reset is released.
REQ-022 Reset asserted mid-switch SHALL abort immediately to reset values with no error pulse; active_profile_o returns to 0.

Structure
REQ-023 The state enum and the profile-index width helper SHALL live in a shared package, cfg_profile_pkg.
REQ-024 The block SHALL contain one sub-module: cfg_profile_cnt, a clearable saturating up-counter used for both timeout and settle counting.

Verification
REQ-025 Basic switch: NumChannels=4, acks return 2 cycles after quiesce_req_o rises; request profile 2 -> active_profile_o = 2, cfg_o = profiles_i[2], quiesce high for 2+1+4 cycles, busy_o then falls.
REQ-026 Timeout: one ack stuck at 0, TimeoutCycles=8 -> err_timeout_o pulses once after 8 DRAIN cycles and active_profile_o stays 0.
REQ-027 Invalid index: NumProfiles=3, request index 3 -> err_invalid_o pulses once; no quiesce; busy_o stays 0.
REQ-028 Same profile: request 0 while active is 0 -> no quiesce, no error, req_ready_o stays 1.
REQ-029 Reset in SETTLE: assert rst_i during SETTLE -> all outputs at reset values in the same cycle; active_profile_o = 0.
REQ-030 Boundary race: all acks arrive exactly on the last timeout cycle -> APPLY is entered and no err_timeout_o pulse occurs.
